// File: rtl/spi_xfer_controller.sv
// spi_xfer_controller
//
// Sequences one DATA_WIDTH-bit SPI transfer in master or slave mode, paced by a
// one-cycle baud tick. It drives the shifter load/shift/store strobes and the
// baud-rate-generator clear, and it owns the sticky SPIF/MODF/WCOL flags.
//
// Ports
//   clk, rst     system clock, synchronous active-high reset
//   baud_tick    one pulse per bit (BRG in master mode, SCK edge detector in slave mode)
//   SS           slave select, active low
//   SPE, MSTR    SPI enable and master mode (from SPCR)
//   start        one-cycle pulse on a CPU write to SPDR
//   flag_clr     one-cycle pulse that clears SPIF, MODF and WCOL
//   SPDR_rd_en   load the shifter from SPDR (LOAD state)
//   Shifter_en   shift one bit (RUN state, qualified by baud_tick)
//   SPDR_wr_en   store the shifter into SPDR (DONE state)
//   BRG_clr      hold the BRG in clear unless a master transfer is active
//   idle, busy   no transfer in progress / transfer in progress
//   MSTR_clr     one-cycle request to clear MSTR on a mode fault
//   bit_cnt      bits shifted so far in the current transfer
//   SPIF, MODF, WCOL  sticky status flags
module spi_xfer_controller #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             baud_tick,
  input  logic             SS,
  input  logic             SPE,
  input  logic             MSTR,
  input  logic             start,
  input  logic             flag_clr,
  output logic             SPDR_rd_en,
  output logic             Shifter_en,
  output logic             SPDR_wr_en,
  output logic             BRG_clr,
  output logic             idle,
  output logic             busy,
  output logic             MSTR_clr,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             SPIF,
  output logic             MODF,
  output logic             WCOL
);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDone
  } state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DATA_WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             spif_q, spif_d;
  logic             modf_q, modf_d;
  logic             wcol_q, wcol_d;
  logic             fault_q, fault_d;

  logic fault;
  logic in_xfer;
  logic slave_abort;
  logic spif_set;
  logic wcol_set;

  // Next-state and bit counter
  always_comb begin
    fault       = SPE & MSTR & ~SS;
    in_xfer     = (state_q == StLoad) | (state_q == StRun);
    slave_abort = ~MSTR & SS & in_xfer;

    state_d = state_q;
    cnt_d   = cnt_q;

    if (!SPE) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else if (fault) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else if (slave_abort) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          // SPE is known high in this branch
          if ((MSTR & start & SS) | (~MSTR & ~SS)) begin
            state_d = StLoad;
          end
        end
        StLoad: begin
          cnt_d   = '0;
          state_d = StRun;
        end
        StRun: begin
          if (baud_tick) begin
            if (cnt_q == CntLast) begin
              cnt_d   = '0;
              state_d = StDone;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as flag_clr wins
  always_comb begin
    spif_set = (state_q == StDone) & SPE & ~fault;
    wcol_set = start & (state_q != StIdle);

    spif_d  = spif_set | (spif_q & ~flag_clr);
    modf_d  = fault    | (modf_q & ~flag_clr);
    wcol_d  = wcol_set | (wcol_q & ~flag_clr);
    fault_d = fault;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      spif_q  <= 1'b0;
      modf_q  <= 1'b0;
      wcol_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      spif_q  <= spif_d;
      modf_q  <= modf_d;
      wcol_q  <= wcol_d;
      fault_q <= fault_d;
    end
  end

  // Outputs decoded from the state register
  always_comb begin
    SPDR_rd_en = (state_q == StLoad);
    Shifter_en = (state_q == StRun) & baud_tick;
    SPDR_wr_en = (state_q == StDone);
    idle       = (state_q == StIdle);
    busy       = ~idle;
    BRG_clr    = ~(MSTR & SPE & in_xfer);
    // Rising edge of the fault condition: one pulse even if the fault persists
    MSTR_clr   = fault & ~fault_q;
    bit_cnt    = cnt_q;
    SPIF       = spif_q;
    MODF       = modf_q;
    WCOL       = wcol_q;
  end

endmodule

// File: tb/tb_spi_xfer_controller.sv
// Self-checking bench for spi_xfer_controller. Two instances (8-bit and 16-bit)
// share the stimulus; a scoreboard holds the expected cycle of every load/store
// strobe and the expected cycle and bit_cnt of every shift pulse.
module tb_spi_xfer_controller;

  localparam int unsigned W8  = 8;
  localparam int unsigned W16 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, baud_tick, ss, spe, mstr, start, flag_clr;

  logic       rd8, sh8, wr8, brg8, idle8, busy8, mclr8, spif8, modf8, wcol8;
  logic [2:0] cnt8;
  logic       rd16, sh16, wr16, brg16, idle16, busy16, mclr16, spif16, modf16, wcol16;
  logic [3:0] cnt16;

  spi_xfer_controller #(.DATA_WIDTH(W8)) u_dut8 (
    .clk        (clk),
    .rst        (rst),
    .baud_tick  (baud_tick),
    .SS         (ss),
    .SPE        (spe),
    .MSTR       (mstr),
    .start      (start),
    .flag_clr   (flag_clr),
    .SPDR_rd_en (rd8),
    .Shifter_en (sh8),
    .SPDR_wr_en (wr8),
    .BRG_clr    (brg8),
    .idle       (idle8),
    .busy       (busy8),
    .MSTR_clr   (mclr8),
    .bit_cnt    (cnt8),
    .SPIF       (spif8),
    .MODF       (modf8),
    .WCOL       (wcol8)
  );

  spi_xfer_controller #(.DATA_WIDTH(W16)) u_dut16 (
    .clk        (clk),
    .rst        (rst),
    .baud_tick  (baud_tick),
    .SS         (ss),
    .SPE        (spe),
    .MSTR       (mstr),
    .start      (start),
    .flag_clr   (flag_clr),
    .SPDR_rd_en (rd16),
    .Shifter_en (sh16),
    .SPDR_wr_en (wr16),
    .BRG_clr    (brg16),
    .idle       (idle16),
    .busy       (busy16),
    .MSTR_clr   (mclr16),
    .bit_cnt    (cnt16),
    .SPIF       (spif16),
    .MODF       (modf16),
    .WCOL       (wcol16)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard
  typedef struct {
    int unsigned cyc;
    int unsigned cnt;
  } sh_ev_t;

  sh_ev_t      sh_q[$];
  int unsigned rd_q[$];
  int unsigned wr_q[$];

  bit          sel16 = 1'b0;
  logic        m_rd, m_sh, m_wr;
  logic [31:0] m_cnt;
  assign m_rd  = sel16 ? rd16 : rd8;
  assign m_sh  = sel16 ? sh16 : sh8;
  assign m_wr  = sel16 ? wr16 : wr8;
  assign m_cnt = sel16 ? 32'(cnt16) : 32'(cnt8);

  always @(negedge clk) begin
    sh_ev_t e;
    if (m_rd) begin
      if (rd_q.size() == 0) check("rd_unexpected", m_rd, 1'b0);
      else                  check("rd_cycle", cyc, rd_q.pop_front());
    end
    if (m_sh) begin
      if (sh_q.size() == 0) begin
        check("shift_unexpected", m_sh, 1'b0);
      end else begin
        e = sh_q.pop_front();
        check("shift_cycle", cyc, e.cyc);
        check("shift_bitcnt", m_cnt, e.cnt);
      end
    end
    if (m_wr) begin
      if (wr_q.size() == 0) check("wr_unexpected", m_wr, 1'b0);
      else                  check("wr_cycle", cyc, wr_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Expected events of an 8-bit transfer started at cycle t with a tick every cycle
  task automatic push_xfer(input int unsigned t, input int unsigned nbits, input bit full);
    rd_q.push_back(t + 1);
    for (int k = 0; k < int'(nbits); k++) sh_q.push_back('{t + 2 + k, k});
    if (full) wr_q.push_back(t + 2 + W8);
  endtask

  int unsigned t;

  initial begin
    rst = 1'b1; baud_tick = 1'b0; ss = 1'b1; spe = 1'b0; mstr = 1'b0;
    start = 1'b0; flag_clr = 1'b0;

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_idle", idle8, 1'b1);
    check("rst_busy", busy8, 1'b0);
    check("rst_brg_clr", brg8, 1'b1);
    check("rst_strobes", {rd8, sh8, wr8, mclr8}, 4'b0000);
    check("rst_bitcnt", cnt8, 3'd0);
    check("rst_flags", {spif8, modf8, wcol8}, 3'b000);

    // Ticks in IDLE are ignored
    step(); spe = 1'b1; mstr = 1'b1; baud_tick = 1'b1;
    step();
    @(negedge clk);
    check("idle_tick_bitcnt", cnt8, 3'd0);

    // A: master basic, tick every clock
    step(); start = 1'b1; t = cyc; push_xfer(t, W8, 1'b1);
    for (int i = 0; i <= 12; i++) begin
      if (i != 0) begin
        step(); start = 1'b0;
      end
      @(negedge clk);
      check("a_brg_clr", brg8, !(i >= 1 && i <= 9));
      check("a_idle", idle8, (i == 0 || i >= 11));
      check("a_busy", busy8, (i >= 1 && i <= 10));
      check("a_spif", spif8, (i >= 11));
    end
    step(); flag_clr = 1'b1;
    step(); flag_clr = 1'b0;
    @(negedge clk);
    check("a_spif_cleared", spif8, 1'b0);

    // B: sparse ticks on the 16-bit instance
    do_reset(); sel16 = 1'b1;
    step(); t = cyc;
    rd_q.push_back(t + 1);
    wr_q.push_back(t + 65);
    for (int i = 0; i <= 68; i++) begin
      if (i != 0) step();
      start     = (i == 0);
      baud_tick = (i % 4 == 0);
      if (i % 4 == 0 && i >= 4 && i <= 64) sh_q.push_back('{t + i, i / 4 - 1});
      @(negedge clk);
      if (i == 65) check("b_bitcnt_wrap", cnt16, 4'd0);
      if (i == 66) begin
        check("b_spif", spif16, 1'b1);
        check("b_idle", idle16, 1'b1);
      end
    end

    // C: mode fault at RUN bit 3
    do_reset(); sel16 = 1'b0; mstr = 1'b1; ss = 1'b1; spe = 1'b1; baud_tick = 1'b1;
    step(); t = cyc; start = 1'b1; push_xfer(t, 3, 1'b0);
    step(); start = 1'b0;
    repeat (3) step();
    step(); ss = 1'b0; baud_tick = 1'b0;
    @(negedge clk);
    check("c_bitcnt_at_fault", cnt8, 3'd3);
    check("c_mstr_clr_pulse", mclr8, 1'b1);
    step(); baud_tick = 1'b1;
    @(negedge clk);
    check("c_mstr_clr_low", mclr8, 1'b0);
    check("c_modf", modf8, 1'b1);
    check("c_idle", idle8, 1'b1);
    check("c_bitcnt_clr", cnt8, 3'd0);
    check("c_spif", spif8, 1'b0);
    step();
    @(negedge clk);
    check("c_mstr_clr_once", mclr8, 1'b0);
    step(); mstr = 1'b0; ss = 1'b1;
    step(); flag_clr = 1'b1;
    @(negedge clk);
    check("c_spif_still0", spif8, 1'b0);
    step(); flag_clr = 1'b0;
    @(negedge clk);
    check("c_modf_cleared", modf8, 1'b0);

    // D: slave abort after 5 ticks, then a full slave transfer
    do_reset(); mstr = 1'b0; ss = 1'b1; spe = 1'b1; baud_tick = 1'b1;
    step(); t = cyc; ss = 1'b0; push_xfer(t, 5, 1'b0);
    repeat (7) step();
    ss = 1'b1; baud_tick = 1'b0;
    step(); baud_tick = 1'b1;
    @(negedge clk);
    check("d_abort_idle", idle8, 1'b1);
    check("d_abort_bitcnt", cnt8, 3'd0);
    check("d_abort_spif", spif8, 1'b0);
    repeat (2) step();
    t = cyc; ss = 1'b0; push_xfer(t, W8, 1'b1);
    repeat (5) step();
    @(negedge clk);
    check("d_brg_slave", brg8, 1'b1);
    repeat (5) step(); ss = 1'b1;
    step();
    @(negedge clk);
    check("d_spif", spif8, 1'b1);
    check("d_idle", idle8, 1'b1);
    step();
    @(negedge clk);
    check("d_stays_idle", idle8, 1'b1);

    // E: write collision, then flag_clr coinciding with a SPIF set
    do_reset(); mstr = 1'b1; ss = 1'b1; spe = 1'b1; baud_tick = 1'b1;
    step(); t = cyc; start = 1'b1; push_xfer(t, W8, 1'b1);
    step(); start = 1'b0;
    repeat (4) step(); start = 1'b1;
    @(negedge clk);
    check("e_wcol_before", wcol8, 1'b0);
    step(); start = 1'b0;
    @(negedge clk);
    check("e_wcol_set", wcol8, 1'b1);
    repeat (5) step();
    @(negedge clk);
    check("e_spif", spif8, 1'b1);
    check("e_wcol_kept", wcol8, 1'b1);
    check("e_idle", idle8, 1'b1);
    repeat (2) step(); t = cyc; start = 1'b1; push_xfer(t, W8, 1'b1);
    step(); start = 1'b0;
    repeat (9) step(); flag_clr = 1'b1;
    step(); flag_clr = 1'b0;
    @(negedge clk);
    check("e_set_beats_clr", spif8, 1'b1);
    check("e_wcol_cleared", wcol8, 1'b0);
    step();
    @(negedge clk);
    check("e_spif_hold", spif8, 1'b1);

    // F: reset mid-RUN with flags set
    step(); t = cyc; start = 1'b1; push_xfer(t, 3, 1'b0);
    step(); start = 1'b0;
    repeat (2) step(); start = 1'b1;
    step(); start = 1'b0;
    step(); rst = 1'b1; baud_tick = 1'b0;
    @(negedge clk);
    check("f_flags_before", {spif8, wcol8}, 2'b11);
    step(); rst = 1'b0; baud_tick = 1'b1;
    @(negedge clk);
    check("f_flags_after", {spif8, modf8, wcol8}, 3'b000);
    check("f_idle", idle8, 1'b1);
    check("f_brg_clr", brg8, 1'b1);
    check("f_bitcnt", cnt8, 3'd0);

    // G: SPE dropped mid-RUN keeps the flags
    step(); t = cyc; start = 1'b1; push_xfer(t, W8, 1'b1);
    step(); start = 1'b0;
    repeat (10) step();
    @(negedge clk);
    check("g_spif", spif8, 1'b1);
    step(); t = cyc; start = 1'b1; push_xfer(t, 3, 1'b0);
    step(); start = 1'b0;
    step();
    step(); start = 1'b1;
    step(); start = 1'b0;
    step(); spe = 1'b0; baud_tick = 1'b0;
    step(); baud_tick = 1'b1;
    @(negedge clk);
    check("g_idle", idle8, 1'b1);
    check("g_bitcnt", cnt8, 3'd0);
    check("g_flags_kept", {spif8, modf8, wcol8}, 3'b101);
    check("g_brg_clr", brg8, 1'b1);
    step(); spe = 1'b1;
    step();
    @(negedge clk);
    check("g_stays_idle", idle8, 1'b1);

    // Every expected event must have been consumed
    repeat (3) step();
    check("sb_rd_left", rd_q.size(), 0);
    check("sb_shift_left", sh_q.size(), 0);
    check("sb_wr_left", wr_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
